eth_axis_frame_gen: RTL and testbench



---
 rtl/eth_axis_frame_gen_pkg.sv | 14 +
 rtl/eth_axis_frame_gen_if.sv | 15 +
 rtl/eth_axis_frame_gen.sv | 144 ++++++++++++++
 tb/tb_eth_axis_frame_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_axis_frame_gen_pkg.sv
// Shared definitions for the Ethernet AXI-stream frame generator and its companion checker.
package eth_axis_frame_gen_pkg;

    localparam int ETH_HDR_LEN = 14;
    localparam int MAC_W       = 48;
    localparam int ETYPE_W     = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

endpackage

// File: rtl/eth_axis_frame_gen_if.sv
// Byte-wide AXI-stream link from the frame generator into the MAC transmit path.
// A beat transfers on a clock edge where tvalid and tready are both 1; once tvalid
// is raised it holds, with tdata/tlast/tuser stable, until that transfer happens.
interface eth_axis_frame_gen_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/eth_axis_frame_gen.sv
// Builds dst/src/ethertype header plus an incrementing payload and streams it byte by byte.
// Preamble and FCS are left to the MAC.
module eth_axis_frame_gen
    import eth_axis_frame_gen_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1500,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   logic_clk,
    input  logic                   logic_rst_n,
    input  logic                   start,
    input  logic [MAC_W-1:0]       cfg_dst_mac,
    input  logic [MAC_W-1:0]       cfg_src_mac,
    input  logic [ETYPE_W-1:0]     cfg_ethertype,
    input  logic [LEN_WIDTH-1:0]   cfg_payload_len,
    input  logic [7:0]             cfg_seed,
    input  logic                   cfg_bad_frame,
    eth_axis_frame_gen_if.master   m_axis,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   frame_count,
    output state_t                 dbg_state
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(MAX_PAYLOAD);
    localparam logic [LEN_WIDTH-1:0] HDR_LAST = LEN_WIDTH'(ETH_HDR_LEN - 1);
    localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);

    state_t               state;
    logic [MAC_W-1:0]     dst_q;
    logic [MAC_W-1:0]     src_q;
    logic [ETYPE_W-1:0]   etype_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] idx;
    logic [LEN_WIDTH-1:0] idx_nxt;
    logic [7:0]           seed_q;
    logic                 bad_q;
    logic                 hs;
    logic                 hdr_last_nxt;
    logic                 pay_last_nxt;

    assign idx_nxt      = idx + ONE;
    assign hs           = m_axis.tvalid && m_axis.tready;
    assign dbg_state    = state;
    // Whether the beat loaded on this handshake closes the frame.
    assign hdr_last_nxt = (idx_nxt == HDR_LAST) && (len_q == '0);
    assign pay_last_nxt = ((idx_nxt + ONE) == len_q);

    function automatic logic [7:0] hdr_byte(input logic [3:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            4'd0:  b = dst_q[47:40];
            4'd1:  b = dst_q[39:32];
            4'd2:  b = dst_q[31:24];
            4'd3:  b = dst_q[23:16];
            4'd4:  b = dst_q[15:8];
            4'd5:  b = dst_q[7:0];
            4'd6:  b = src_q[47:40];
            4'd7:  b = src_q[39:32];
            4'd8:  b = src_q[31:24];
            4'd9:  b = src_q[23:16];
            4'd10: b = src_q[15:8];
            4'd11: b = src_q[7:0];
            4'd12: b = etype_q[15:8];
            4'd13: b = etype_q[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge logic_clk) begin
        if (!logic_rst_n) begin
            state         <= IDLE;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
            m_axis.tdata  <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
            frame_count   <= '0;
            idx           <= '0;
            len_q         <= '0;
            dst_q         <= '0;
            src_q         <= '0;
            etype_q       <= '0;
            seed_q        <= 8'h00;
            bad_q         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dst_q         <= cfg_dst_mac;
                        src_q         <= cfg_src_mac;
                        etype_q       <= cfg_ethertype;
                        seed_q        <= cfg_seed;
                        bad_q         <= cfg_bad_frame;
                        len_q         <= (cfg_payload_len > LEN_MAX) ? LEN_MAX : cfg_payload_len;
                        idx           <= '0;
                        busy          <= 1'b1;
                        m_axis.tvalid <= 1'b1;
                        m_axis.tdata  <= cfg_dst_mac[47:40];
                        m_axis.tlast  <= 1'b0;
                        m_axis.tuser  <= 1'b0;
                        state         <= HEADER;
                    end
                end
                HEADER, PAYLOAD: begin
                    if (hs) begin
                        if (m_axis.tlast) begin
                            state         <= IDLE;
                            m_axis.tvalid <= 1'b0;
                            m_axis.tlast  <= 1'b0;
                            m_axis.tuser  <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            frame_count   <= frame_count + CNT_WIDTH'(1);
                        end else if (state == HEADER && idx == HDR_LAST) begin
                            state        <= PAYLOAD;
                            idx          <= '0;
                            m_axis.tdata <= seed_q;
                            m_axis.tlast <= (len_q == ONE);
                            m_axis.tuser <= (len_q == ONE) && bad_q;
                        end else if (state == HEADER) begin
                            idx          <= idx_nxt;
                            m_axis.tdata <= hdr_byte(idx_nxt[3:0]);
                            m_axis.tlast <= hdr_last_nxt;
                            m_axis.tuser <= hdr_last_nxt && bad_q;
                        end else begin
                            idx          <= idx_nxt;
                            m_axis.tdata <= m_axis.tdata + 8'd1;
                            m_axis.tlast <= pay_last_nxt;
                            m_axis.tuser <= pay_last_nxt && bad_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_axis_frame_gen.sv
// Directed bench for eth_axis_frame_gen: per-beat scoreboard plus handshake, timing and reset checks.
module tb_eth_axis_frame_gen;
  import eth_axis_frame_gen_pkg::*;

  localparam int MAX_PAYLOAD = 1500;
  localparam int LEN_WIDTH   = 16;
  localparam int CNT_WIDTH   = 32;

  logic                 logic_clk = 1'b0;
  logic                 logic_rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [47:0]          cfg_dst_mac = '0;
  logic [47:0]          cfg_src_mac = '0;
  logic [15:0]          cfg_ethertype = '0;
  logic [LEN_WIDTH-1:0] cfg_payload_len = '0;
  logic [7:0]           cfg_seed = '0;
  logic                 cfg_bad_frame = 1'b0;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] frame_count;
  state_t               dbg_state;

  logic rand_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  // scoreboard entries are {tlast, tuser, tdata}
  logic [9:0] exp_q[$];
  int hs_total = 0;
  int tlast_total = 0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  eth_axis_frame_gen_if m_axis();

  eth_axis_frame_gen #(
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .LEN_WIDTH(LEN_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .logic_clk(logic_clk),
    .logic_rst_n(logic_rst_n),
    .start(start),
    .cfg_dst_mac(cfg_dst_mac),
    .cfg_src_mac(cfg_src_mac),
    .cfg_ethertype(cfg_ethertype),
    .cfg_payload_len(cfg_payload_len),
    .cfg_seed(cfg_seed),
    .cfg_bad_frame(cfg_bad_frame),
    .m_axis(m_axis),
    .busy(busy),
    .done(done),
    .frame_count(frame_count),
    .dbg_state(dbg_state)
  );

  // clock / reset-independent ready driver
  always #5 logic_clk = ~logic_clk;

  always @(posedge logic_clk) begin
    #1;
    m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor: inputs settle at posedge+1, so the negedge sees what the next edge will sample
  always @(negedge logic_clk) begin
    logic [9:0] beat;
    logic [9:0] exp;
    if (logic_rst_n) begin
      beat = {m_axis.tlast, m_axis.tuser, m_axis.tdata};
      if (prev_stall) begin
        chk("stall_tvalid", 32'(m_axis.tvalid), 32'd1);
        chk("stall_beat", 32'(beat), 32'(prev_beat));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        hs_total++;
        if (m_axis.tlast) tlast_total++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'bx;
        chk("beat", 32'(beat), 32'(exp));
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_beat  = beat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge logic_clk);
    #1;
  endtask

  task automatic set_cfg(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                         input int len, input logic [7:0] seed, input logic bad);
    cfg_dst_mac     = dst;
    cfg_src_mac     = src;
    cfg_ethertype   = et;
    cfg_payload_len = LEN_WIDTH'(len);
    cfg_seed        = seed;
    cfg_bad_frame   = bad;
  endtask

  task automatic push_frame();
    int n;
    logic [111:0] hdr;
    logic [7:0] b;
    logic last;
    n = (int'(cfg_payload_len) > MAX_PAYLOAD) ? MAX_PAYLOAD : int'(cfg_payload_len);
    hdr = {cfg_dst_mac, cfg_src_mac, cfg_ethertype};
    for (int i = 0; i < 14; i++) begin
      b = hdr[111 - 8*i -: 8];
      last = (n == 0) && (i == 13);
      exp_q.push_back({last, last & cfg_bad_frame, b});
    end
    for (int k = 0; k < n; k++) begin
      b = cfg_seed + 8'(k);
      last = (k == n - 1);
      exp_q.push_back({last, last & cfg_bad_frame, b});
    end
  endtask

  task automatic start_frame(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_first_tvalid"}, 32'(m_axis.tvalid), 32'd1);
    chk({tag, "_first_byte"}, 32'(m_axis.tdata), 32'(cfg_dst_mac[47:40]));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_tvalid_after"}, 32'(m_axis.tvalid), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int hs0;
    int tl0;
    int n;

    // reset
    logic_rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis.tlast), 32'd0);
    chk("rst_tuser", 32'(m_axis.tuser), 32'd0);
    chk("rst_tdata", 32'(m_axis.tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", frame_count, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    logic_rst_n = 1'b1;
    tick();

    // header-only frame
    set_cfg(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h0800, 0, 8'h00, 1'b0);
    push_frame();
    hs0 = hs_total;
    start_frame("hdr");
    wait_done("hdr", 100, cyc);
    chk("hdr_cycles", 32'(cyc), 32'd14);
    chk("hdr_beats", 32'(hs_total - hs0), 32'd14);
    chk("hdr_count", frame_count, 32'd1);
    tick();
    chk("hdr_done_1cyc", 32'(done), 32'd0);

    // payload with byte wrap
    set_cfg(48'h11_22_33_44_55_66, 48'hAA_BB_CC_DD_EE_FF, 16'h88B5, 300, 8'hF0, 1'b0);
    push_frame();
    hs0 = hs_total;
    start_frame("wrap");
    wait_done("wrap", 1000, cyc);
    chk("wrap_cycles", 32'(cyc), 32'd314);
    chk("wrap_beats", 32'(hs_total - hs0), 32'd314);
    chk("wrap_count", frame_count, 32'd2);
    tick();

    // random backpressure
    rand_ready = 1'b1;
    set_cfg(48'h01_02_03_04_05_06, 48'h0A_0B_0C_0D_0E_0F, 16'h86DD, 4, 8'h55, 1'b1);
    push_frame();
    hs0 = hs_total;
    start_frame("bp");
    wait_done("bp", 500, cyc);
    chk("bp_beats", 32'(hs_total - hs0), 32'd18);
    chk("bp_count", frame_count, 32'd3);
    rand_ready = 1'b0;
    tick();
    tick();

    // length clamp with bad-frame marker
    set_cfg(48'hDE_AD_BE_EF_00_01, 48'hCA_FE_00_00_00_02, 16'h0806, 2000, 8'h3C, 1'b1);
    push_frame();
    hs0 = hs_total;
    start_frame("clamp");
    wait_done("clamp", 3000, cyc);
    chk("clamp_beats", 32'(hs_total - hs0), 32'd1514);
    chk("clamp_cycles", 32'(cyc), 32'd1514);
    chk("clamp_count", frame_count, 32'd4);
    tick();

    // start and cfg changes while busy are ignored; start on done chains a frame
    set_cfg(48'h02_00_00_00_00_0A, 48'h02_00_00_00_00_0B, 16'h0800, 20, 8'h80, 1'b0);
    push_frame();
    hs0 = hs_total;
    start_frame("busy");
    repeat (5) tick();
    set_cfg(48'hFF_FF_FF_FF_FF_FF, 48'h12_34_56_78_9A_BC, 16'h1234, 7, 8'h01, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy", 200, cyc);
    chk("busy_beats", 32'(hs_total - hs0), 32'd34);
    chk("busy_count", frame_count, 32'd5);
    push_frame();
    hs0 = hs_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("chain_done_1cyc", 32'(done), 32'd0);
    chk("chain_tvalid", 32'(m_axis.tvalid), 32'd1);
    chk("chain_first_byte", 32'(m_axis.tdata), 32'hFF);
    wait_done("chain", 200, cyc);
    chk("chain_beats", 32'(hs_total - hs0), 32'd21);
    chk("chain_count", frame_count, 32'd6);
    repeat (3) tick();
    chk("no_extra_frame", 32'(m_axis.tvalid), 32'd0);

    // reset in the middle of a frame
    set_cfg(48'h02_00_00_00_00_21, 48'h02_00_00_00_00_22, 16'h0800, 50, 8'h10, 1'b0);
    push_frame();
    hs0 = hs_total;
    tl0 = tlast_total;
    start_frame("mid");
    n = 0;
    while ((hs_total - hs0) < 7 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_beats_before_rst", 32'(hs_total - hs0), 32'd7);
    logic_rst_n = 1'b0;
    tick();
    exp_q.delete();
    chk("mid_rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", frame_count, 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_no_tlast", 32'(tlast_total - tl0), 32'd0);
    logic_rst_n = 1'b1;
    tick();
    set_cfg(48'h02_00_00_00_00_31, 48'h02_00_00_00_00_32, 16'h0800, 10, 8'hFA, 1'b0);
    push_frame();
    hs0 = hs_total;
    start_frame("fresh");
    wait_done("fresh", 200, cyc);
    chk("fresh_beats", 32'(hs_total - hs0), 32'd24);
    chk("fresh_count", frame_count, 32'd1);
    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
